axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Read-channel scheduler between the CPU's instruction and data SRAM-like ports and the single AXI AR/R channel of the bridge.
- Arbitrates the two requesters round-robin, holds one AR beat at a time, and caps outstanding reads per requester.
- Stalls data reads that hit an unacknowledged write, tags each read with an ID, and routes R beats back by rid.

Parameters:
- MAX_OUTST, 4: maximum outstanding (accepted, not yet returned) reads per requester; must be 1..7.
- CNT_W, 3: width of each outstanding counter; must hold MAX_OUTST.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- inst_req  in  1  instruction read request.
- inst_addr  in  32  instruction byte address.
- inst_size  in  2  log2 bytes.
- inst_addr_ok  out  1  request accepted this cycle.
- inst_data_ok  out  1  instruction read data valid.
- inst_rdata  out  32  instruction read data.
- data_req  in  1  data read request (reads only; writes bypass this block).
- data_addr  in  32  data byte address.
- data_size  in  2  log2 bytes.
- data_addr_ok  out  1  request accepted this cycle.
- data_data_ok  out  1  data read data valid.
- data_rdata  out  32  data read data.
- wr_pending  in  1  write path has a write awaiting its B response.
- wr_addr  in  32  address of the newest pending write.
- arid  out  4  0 = inst, 1 = data.
- araddr  out  32  read address.
- arsize  out  3  read size.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  4  R id.
- rdata  in  32  R data.
- rvalid  in  1  R valid.
- rready  out  1  R ready.

Behaviour:
- Reset values:
  - arvalid = 0, arid = 0, araddr = 0, arsize = 0.
  - Both outstanding counters = 0; state = IDLE; last_grant = DATA, so inst wins the first tie.
  - rready = 1. All *_addr_ok and *_data_ok = 0.
- State machine, states IDLE and AR_BUSY:
  - In IDLE, requester X is eligible when X_req = 1 and cnt_X < MAX_OUTST.
  - Data is additionally ineligible when wr_pending = 1 and wr_addr[31:2] == data_addr[31:2] (RAW hazard; data_addr_ok stays 0 until the condition clears).
- Arbitration:
  - If both are eligible, grant the one not equal to last_grant.
  - If one is eligible, grant it.
  - X_addr_ok is combinational: it equals (state == IDLE) & grant_X. Only one addr_ok may be high per cycle.
- On grant:
  - Register araddr = X_addr, arsize = {1'b0, X_size}, arid = X id.
  - Update last_grant and go to AR_BUSY.
  - arvalid is asserted from the next cycle.
- In AR_BUSY:
  - arvalid = 1, and the AR fields stay stable until arready.
  - On arready, drop arvalid and return to IDLE in the next cycle. Accept rate is at most one request per 2 cycles.
- Outstanding counters:
  - cnt_X increments on X_addr_ok and decrements on the R handshake with rid == X id.
  - Simultaneous increment and decrement leaves the counter unchanged.
  - Counters never wrap: eligibility blocks at MAX_OUTST, and an R beat arriving at count 0 is a protocol error (assertion only, counter held at 0).
- R routing:
  - rready tied to 1.
  - inst_data_ok = rvalid & (rid == 0); data_data_ok = rvalid & (rid == 1).
  - inst_rdata and data_rdata are driven directly from rdata, same cycle, zero latency.
  - Other rid values are ignored.
- Ordering: the slave returns each ID in order, so no reorder buffer is needed.
- A mid-operation reset abandons the in-flight AR and clears the counters. The surrounding system resets the slave together with this block.

Decomposition:
- Shared package `axi_bridge_pkg`: ID_INST = 4'd0, ID_DATA = 4'd1, state encodings, AXI constants (arlen = 0, arburst = INCR).
- These constants are driven by the parent bridge, not by this block.
- One natural sub-module, `outst_counter`: saturating up/down counter with a full flag, instantiated twice.

Test Plan:
- Reset, then inst_req = 1 at 0x1C000000, size 2:
  - inst_addr_ok high in cycle 1; arvalid = 1, araddr = 0x1C000000, arsize = 3'b010, arid = 0 in the next cycle.
  - arready = 1 returns the FSM to IDLE.
  - rvalid with rid = 0 and rdata = 0xDEADBEEF gives inst_data_ok = 1 and inst_rdata = 0xDEADBEEF.
- inst_req and data_req both held high for 8 accepts:
  - Grants alternate inst, data, inst, data, …; arid alternates 0, 1.
- data_req at 0x1000 with wr_pending = 1 and wr_addr = 0x1002:
  - data_addr_ok stays 0. It goes high the first IDLE cycle after wr_pending falls.
  - Under the same stall, wr_addr = 0x1004 lets the request be granted immediately.
- inst_req held, arready always 1, no R beats:
  - Exactly 4 inst_addr_ok pulses, then none.
  - One rid = 0 beat lets exactly one more request be accepted.
- rvalid (rid = 1) in the same cycle as data_addr_ok with cnt_data = 2:
  - cnt_data remains 2.
- Reset asserted while arvalid = 1 and arready = 0:
  - Next cycle arvalid = 0, both counters = 0, FSM in IDLE.

Source files
------------

// File: rtl/axi_bridge_pkg.sv
// rtl/axi_bridge_pkg.sv - shared types and constants for the AXI read bridge
//
// Purpose: read IDs, read-scheduler state encodings, grant encoding and the
// fixed AXI AR attributes that the parent bridge drives (single-beat INCR).
// Ports: none (package).

package axi_bridge_pkg;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  // Every read is a single beat; the parent bridge ties these on the bus.
  localparam logic [7:0] AXI_ARLEN        = 8'd0;
  localparam logic [1:0] AXI_ARBURST_INCR = 2'b01;

  typedef enum logic {
    IDLE    = 1'b0,
    AR_BUSY = 1'b1
  } rd_state_t;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_t;

endpackage

// File: rtl/outst_counter.sv
// rtl/outst_counter.sv - saturating outstanding-read counter with full flag
//
// Purpose: tracks reads accepted but not yet returned for one requester.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   inc         a request of this requester was accepted this cycle
//   dec         an R beat for this requester was handshaken this cycle
//   cnt         current outstanding count
//   full        cnt has reached MAX; the requester must not be granted

module outst_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         full
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  assign full = (cnt >= MAX_C);

  // inc and dec together cancel out. Neither direction may wrap: inc is
  // blocked upstream by full, and a stray dec at zero is held at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(dec && (cnt == '0)));

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(inc && !dec && full));

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - round-robin inst/data read scheduler onto one AXI AR/R channel
//
// Purpose: arbitrates the instruction and data SRAM-like read ports, issues
// one AR beat at a time, caps outstanding reads per requester, stalls data
// reads that alias a pending write, and routes R beats back by rid.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   inst_req/addr/size -> addr_ok       instruction read request port
//   inst_data_ok, inst_rdata            instruction read return
//   data_req/addr/size -> addr_ok       data read request port
//   data_data_ok, data_rdata            data read return
//   wr_pending, wr_addr                 newest unacknowledged write (RAW check)
//   arid/araddr/arsize/arvalid/arready  AXI read address channel
//   rid/rdata/rvalid/rready             AXI read data channel

module axi_rd_arbiter #(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        wr_pending,
  input  logic [31:0] wr_addr,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready
);

  import axi_bridge_pkg::*;

  rd_state_t  state_q, next_state;
  grant_t     last_grant_q;
  logic       grant_inst, grant_data;
  logic       elig_inst, elig_data, raw_hazard;
  logic       inst_full, data_full;
  logic       inst_ret, data_ret;
  logic [CNT_W-1:0] cnt_inst, cnt_data;

  // Byte lanes within a word do not matter for the hazard compare.
  logic unused_low_bits;
  assign unused_low_bits = &{1'b0, wr_addr[1:0], data_addr[1:0]};

  // Word-granular RAW check against the newest pending write.
  assign raw_hazard = wr_pending && (wr_addr[31:2] == data_addr[31:2]);
  assign elig_inst  = inst_req && !inst_full;
  assign elig_data  = data_req && !data_full && !raw_hazard;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    next_state = state_q;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    case (state_q)
      IDLE: begin
        if (elig_inst && (!elig_data || (last_grant_q == GRANT_DATA))) begin
          grant_inst = 1'b1;
        end else if (elig_data) begin
          grant_data = 1'b1;
        end
        if (grant_inst || grant_data) begin
          next_state = AR_BUSY;
        end
      end
      AR_BUSY: begin
        if (arready) begin
          next_state = IDLE;
        end
      end
    endcase
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign arvalid      = (state_q == AR_BUSY);

  // AR fields are captured at grant and held through AR_BUSY.
  always_ff @(posedge clk) begin
    if (reset) begin
      araddr       <= '0;
      arsize       <= '0;
      arid         <= '0;
      last_grant_q <= GRANT_DATA;
    end else if (grant_inst) begin
      araddr       <= inst_addr;
      arsize       <= {1'b0, inst_size};
      arid         <= ID_INST;
      last_grant_q <= GRANT_INST;
    end else if (grant_data) begin
      araddr       <= data_addr;
      arsize       <= {1'b0, data_size};
      arid         <= ID_DATA;
      last_grant_q <= GRANT_DATA;
    end
  end

  // The slave returns each ID in order, so beats go straight through.
  assign rready       = 1'b1;
  assign inst_ret     = rvalid && (rid == ID_INST);
  assign data_ret     = rvalid && (rid == ID_DATA);
  assign inst_data_ok = inst_ret;
  assign data_data_ok = data_ret;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  outst_counter #(.MAX(MAX_OUTST), .W(CNT_W)) u_cnt_inst (
    .clk   (clk),
    .reset (reset),
    .inc   (grant_inst),
    .dec   (inst_ret),
    .cnt   (cnt_inst),
    .full  (inst_full)
  );

  outst_counter #(.MAX(MAX_OUTST), .W(CNT_W)) u_cnt_data (
    .clk   (clk),
    .reset (reset),
    .inc   (grant_data),
    .dec   (data_ret),
    .cnt   (cnt_data),
    .full  (data_full)
  );

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - self-checking bench for axi_rd_arbiter

module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req, wr_pending, arready, rvalid;
  logic [31:0] inst_addr, data_addr, wr_addr, rdata;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  rid;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, araddr;
  logic [3:0]  arid;
  logic [2:0]  arsize;
  logic        arvalid, rready;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
  } ar_exp_t;

  ar_exp_t exp_q[$];

  axi_rd_arbiter #(.MAX_OUTST(4), .CNT_W(3)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_size    (inst_size),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_addr    (data_addr),
    .data_size    (data_size),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .wr_pending   (wr_pending),
    .wr_addr      (wr_addr),
    .arid         (arid),
    .araddr       (araddr),
    .arsize       (arsize),
    .arvalid      (arvalid),
    .arready      (arready),
    .rid          (rid),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .rready       (rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ar(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] size);
    ar_exp_t e;
    e.id = id; e.addr = addr; e.size = size;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    inst_req = 0; data_req = 0; wr_pending = 0; arready = 0; rvalid = 0;
    inst_addr = 0; data_addr = 0; wr_addr = 0; rdata = 0; rid = 0;
    inst_size = 0; data_size = 0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // AR scoreboard: every handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (!reset && arvalid && arready) begin
      if (exp_q.size() == 0) begin
        chk("ar_unexpected", 32'(araddr), 32'hFFFF_FFFF);
      end else begin
        ar_exp_t e;
        e = exp_q.pop_front();
        chk("ar_id",   32'(arid),   32'(e.id));
        chk("ar_addr", araddr,      e.addr);
        chk("ar_size", 32'(arsize), 32'(e.size));
      end
    end
  end

  initial begin
    int n_acc;
    int seen;

    // Reset values
    do_reset();
    #1;
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_araddr",  araddr, 0);
    chk("rst_arid",    32'(arid), 0);
    chk("rst_arsize",  32'(arsize), 0);
    chk("rst_rready",  32'(rready), 1);
    chk("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 0);
    chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 0);
    tick();

    // Single instruction read
    inst_req = 1; inst_addr = 32'h1C00_0000; inst_size = 2'd2;
    push_ar(4'd0, 32'h1C00_0000, 3'b010);
    #1;
    chk("t1_inst_addr_ok", 32'(inst_addr_ok), 1);
    chk("t1_data_addr_ok", 32'(data_addr_ok), 0);
    tick();
    inst_req = 0;
    #1;
    chk("t1_arvalid", 32'(arvalid), 1);
    chk("t1_araddr",  araddr, 32'h1C00_0000);
    chk("t1_arsize",  32'(arsize), 32'b010);
    chk("t1_arid",    32'(arid), 0);
    arready = 1;
    tick();
    arready = 0;
    #1;
    chk("t1_arvalid_drop", 32'(arvalid), 0);
    rvalid = 1; rid = 4'd0; rdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_inst_data_ok", 32'(inst_data_ok), 1);
    chk("t1_inst_rdata",   inst_rdata, 32'hDEAD_BEEF);
    chk("t1_data_data_ok", 32'(data_data_ok), 0);
    tick();
    rid = 4'd2; rdata = 32'h5555_AAAA;
    #1;
    chk("t1_rid2_ignored", 32'({inst_data_ok, data_data_ok}), 0);
    tick();
    rvalid = 0;
    chk("t1_cnt_inst", 32'(u_dut.cnt_inst), 0);

    // Round-robin with both requesters always asking
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) push_ar(4'd0, 32'h0000_0100, 3'b010);
      else            push_ar(4'd1, 32'h0000_2000, 3'b001);
    end
    inst_req = 1; inst_addr = 32'h0000_0100; inst_size = 2'd2;
    data_req = 1; data_addr = 32'h0000_2000; data_size = 2'd1;
    arready = 1;
    n_acc = 0;
    for (int cyc = 0; cyc < 40 && n_acc < 8; cyc++) begin
      #1;
      if (inst_addr_ok || data_addr_ok) begin
        chk("t2_grant", 32'({inst_addr_ok, data_addr_ok}),
            (n_acc % 2 == 0) ? 32'b10 : 32'b01);
        n_acc++;
      end
      tick();
    end
    inst_req = 0; data_req = 0;
    chk("t2_accepts", n_acc, 8);
    tick();
    arready = 0;
    chk("t2_q_drained", exp_q.size(), 0);

    // RAW stall on a pending write to the same word
    do_reset();
    data_req = 1; data_addr = 32'h0000_1000; data_size = 2'd2;
    wr_pending = 1; wr_addr = 32'h0000_1002;
    seen = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      #1;
      if (data_addr_ok) seen++;
      tick();
    end
    chk("t3_stalled", seen, 0);
    wr_pending = 0;
    push_ar(4'd1, 32'h0000_1000, 3'b010);
    #1;
    chk("t3_release", 32'(data_addr_ok), 1);
    tick();
    data_req = 0;
    arready = 1;
    tick();
    arready = 0;
    wr_pending = 1; wr_addr = 32'h0000_1004;
    data_req = 1; data_size = 2'd1;
    push_ar(4'd1, 32'h0000_1000, 3'b001);
    #1;
    chk("t3_other_word", 32'(data_addr_ok), 1);
    tick();
    data_req = 0; wr_pending = 0;
    arready = 1;
    tick();
    arready = 0;
    chk("t3_cnt_data", 32'(u_dut.cnt_data), 2);

    // Accept and return for the same requester in one cycle
    data_req = 1; data_addr = 32'h0000_3000; data_size = 2'd2;
    rvalid = 1; rid = 4'd1; rdata = 32'h1234_5678;
    push_ar(4'd1, 32'h0000_3000, 3'b010);
    #1;
    chk("t5_addr_ok", 32'(data_addr_ok), 1);
    chk("t5_data_ok", 32'(data_data_ok), 1);
    chk("t5_rdata",   data_rdata, 32'h1234_5678);
    tick();
    data_req = 0; rvalid = 0;
    chk("t5_cnt_hold", 32'(u_dut.cnt_data), 2);
    arready = 1;
    tick();
    arready = 0;
    chk("t5_q_drained", exp_q.size(), 0);

    // Outstanding cap
    do_reset();
    for (int i = 0; i < 4; i++) push_ar(4'd0, 32'h0000_0040, 3'b010);
    inst_req = 1; inst_addr = 32'h0000_0040; inst_size = 2'd2;
    arready = 1;
    n_acc = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      #1;
      if (inst_addr_ok) n_acc++;
      tick();
    end
    chk("t4_cap_accepts", n_acc, 4);
    chk("t4_cnt_full", 32'(u_dut.cnt_inst), 4);
    push_ar(4'd0, 32'h0000_0040, 3'b010);
    rvalid = 1; rid = 4'd0; rdata = 32'h0;
    n_acc = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (inst_addr_ok) n_acc++;
      tick();
      rvalid = 0;
    end
    inst_req = 0;
    chk("t4_one_more", n_acc, 1);
    chk("t4_cnt_refull", 32'(u_dut.cnt_inst), 4);
    arready = 0;
    chk("t4_q_drained", exp_q.size(), 0);

    // Reset while an AR is stalled
    do_reset();
    inst_req = 1; inst_addr = 32'h0000_0800; inst_size = 2'd2;
    #1;
    chk("t6_addr_ok", 32'(inst_addr_ok), 1);
    tick();
    inst_req = 0;
    chk("t6_arvalid", 32'(arvalid), 1);
    chk("t6_cnt_pre", 32'(u_dut.cnt_inst), 1);
    reset = 1;
    tick();
    reset = 0;
    chk("t6_arvalid_rst", 32'(arvalid), 0);
    chk("t6_cnt_inst",    32'(u_dut.cnt_inst), 0);
    chk("t6_cnt_data",    32'(u_dut.cnt_data), 0);
    chk("t6_state",       32'(u_dut.state_q), 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
